gsu_cache_fill: RTL and testbench

- Write-side companion to the GSU instruction cache: when the core's fetch misses, this block fetches the 16-byte cache line from the Game Pak bus and writes it into the 512-byte cache RAM.
- Owns the 32 line-valid flags and handles cache flush.
- Sits between the GSU execute core (miss request), the cache RAM write port, and the Game Pak memory arbiter.

---
 rtl/gsu_pkg.sv | 24 ++
 rtl/gsu_cache_addr.sv | 25 ++
 rtl/gsu_cache_fill.sv | 229 ++++++++++++++++++++++
 tb/tb_gsu_cache_fill.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsu_pkg.sv
// gsu_pkg: shared definitions for the GSU instruction-cache fill path.
//   - One-hot fill FSM state encoding (same style as the execute core).
//   - Cache geometry: LINE_BYTES, NUM_LINES, CACHE_AW, LINE_IDX_W.
//   - sat_inc16: saturating 16-bit increment used by the optional
//     performance counters.
package gsu_pkg;

  localparam int LINE_BYTES = 16;
  localparam int NUM_LINES  = 32;
  localparam int CACHE_AW   = 9;
  localparam int LINE_IDX_W = 5;

  // Fill FSM, one-hot
  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_WAIT_BUS = 5'b00010;
  localparam logic [4:0] ST_REQ      = 5'b00100;
  localparam logic [4:0] ST_WRITE    = 5'b01000;
  localparam logic [4:0] ST_DONE     = 5'b10000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gsu_cache_addr.sv
// gsu_cache_addr: cache RAM address and line index for one byte of a line.
//   pc_line  : pc[8:4]   (line-aligned PC, only the bits that reach the RAM)
//   cbr_line : cbr[8:4]  (cache base register, always 16-byte aligned)
//   offset   : byte within the line
//   waddr    : (pc_l + offset + cbr) mod 512
//   line_idx : waddr[8:4]
// Shared with the core's read-side mapping so both agree on placement.
module gsu_cache_addr
  import gsu_pkg::*;
(
  input  logic [LINE_IDX_W-1:0] pc_line,
  input  logic [LINE_IDX_W-1:0] cbr_line,
  input  logic [3:0]            offset,
  output logic [CACHE_AW-1:0]   waddr,
  output logic [LINE_IDX_W-1:0] line_idx
);

  // Both bases are 16-byte aligned, so the offset never carries into the
  // line index; the 5-bit sum wraps the 512-byte RAM naturally.
  always_comb begin
    line_idx = pc_line + cbr_line;
    waddr    = {line_idx, offset};
  end

endmodule

// File: rtl/gsu_cache_fill.sv
// gsu_cache_fill: fetches a 16-byte line from the Game Pak bus on a cache
// miss and writes it into the 512-byte GSU cache RAM; owns the line-valid
// flags and handles flush.
// Ports:
//   clkin, rst                  clock, synchronous active-high reset
//   miss_req/miss_pc/miss_pbr   miss request from the core (level, held)
//   cbr                         cache base register
//   flush                       pulse, invalidates all lines, aborts a fill
//   ron                         GSU owns the ROM bus
//   mem_req/mem_addr            read request to the memory arbiter
//   mem_ack/mem_data            one-cycle acknowledge with data
//   cache_we/waddr/wdata        cache RAM write port
//   line_valid                  per-line valid flags
//   fill_busy/done/abort        fill status
// Optional: define GSU_CACHE_FILL_PERF_EN to add perf_fills (completed
// fills) and perf_stall (busy cycles), both saturating.
module gsu_cache_fill
  import gsu_pkg::*;
(
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [15:0]           miss_pc,
  input  logic [7:0]            miss_pbr,
  input  logic [15:0]           cbr,
  input  logic                  flush,
  input  logic                  ron,
  output logic                  mem_req,
  output logic [23:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic                  cache_we,
  output logic [CACHE_AW-1:0]   cache_waddr,
  output logic [7:0]            cache_wdata,
  output logic [NUM_LINES-1:0]  line_valid,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_abort
`ifdef GSU_CACHE_FILL_PERF_EN
  ,
  output logic [15:0]           perf_fills,
  output logic [15:0]           perf_stall
`endif
);

  localparam logic [3:0] LAST_BYTE = 4'(LINE_BYTES - 1);

  logic [4:0]            state_r, state_n;
  logic [3:0]            cnt_r, cnt_n;
  logic [11:0]           pcl_r;
  logic [7:0]            pbr_r;
  logic [LINE_IDX_W-1:0] cbl_r;
  logic [LINE_IDX_W-1:0] idx_r;
  logic [NUM_LINES-1:0]  line_valid_r;
  logic                  mem_req_r, cache_we_r, fill_busy_r, fill_done_r, fill_abort_r;
  logic [23:0]           mem_addr_r;
  logic [CACHE_AW-1:0]   cache_waddr_r;
  logic [7:0]            cache_wdata_r;

  logic                  accept_s, hit_s, abort_s, finish_s, capture_s;
  logic [LINE_IDX_W-1:0] live_idx_s, fill_idx_s;
  logic [CACHE_AW-1:0]   live_waddr_s, fill_waddr_s;
  logic                  unused_s;

  // Line index of the request presented right now (hit check / latch).
  gsu_cache_addr u_live_addr (
    .pc_line  (miss_pc[8:4]),
    .cbr_line (cbr[8:4]),
    .offset   (4'd0),
    .waddr    (live_waddr_s),
    .line_idx (live_idx_s)
  );

  // Cache address of the byte currently being fetched, from latched values.
  gsu_cache_addr u_fill_addr (
    .pc_line  (pcl_r[4:0]),
    .cbr_line (cbl_r),
    .offset   (cnt_r),
    .waddr    (fill_waddr_s),
    .line_idx (fill_idx_s)
  );

  assign unused_s = ^{miss_pc[3:0], cbr[15:9], cbr[3:0], live_waddr_s, fill_idx_s};

  // Next-state logic; flush overrides everything, including DONE.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    accept_s  = 1'b0;
    hit_s     = 1'b0;
    abort_s   = 1'b0;
    finish_s  = 1'b0;
    capture_s = 1'b0;
    if (flush) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
      abort_s = (state_r != ST_IDLE);
    end else begin
      case (state_r)
        ST_IDLE: begin
          // The cycle showing fill_done still sees the old request held.
          if (miss_req && !fill_done_r) begin
            if (line_valid_r[live_idx_s]) begin
              hit_s = 1'b1;
            end else begin
              accept_s = 1'b1;
              state_n  = ST_WAIT_BUS;
              cnt_n    = 4'd0;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_WAIT_BUS: begin
          if (ron) state_n = ST_REQ;
          else     state_n = ST_WAIT_BUS;
        end
        ST_REQ: begin
          // An ack in the same cycle as losing the bus still delivers data.
          if (mem_ack) begin
            capture_s = 1'b1;
            state_n   = ST_WRITE;
          end else if (!ron) begin
            state_n = ST_WAIT_BUS;
          end else begin
            state_n = ST_REQ;
          end
        end
        ST_WRITE: begin
          if (cnt_r == LAST_BYTE) begin
            state_n = ST_DONE;
          end else begin
            cnt_n   = cnt_r + 4'd1;
            state_n = ST_REQ;
          end
        end
        ST_DONE: begin
          finish_s = 1'b1;
          state_n  = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  // FSM state, byte counter and request fields latched on acceptance.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      pcl_r   <= 12'd0;
      pbr_r   <= 8'd0;
      cbl_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (accept_s) begin
        pcl_r <= miss_pc[15:4];
        pbr_r <= miss_pbr;
        cbl_r <= cbr[8:4];
        idx_r <= live_idx_s;
      end
    end
  end

  // Registered outputs: bus request, cache write port, valid flags, status.
  always_ff @(posedge clkin) begin
    if (rst) begin
      mem_req_r     <= 1'b0;
      mem_addr_r    <= 24'd0;
      cache_we_r    <= 1'b0;
      cache_waddr_r <= '0;
      cache_wdata_r <= 8'd0;
      line_valid_r  <= '0;
      fill_busy_r   <= 1'b0;
      fill_done_r   <= 1'b0;
      fill_abort_r  <= 1'b0;
    end else begin
      mem_req_r <= (state_n == ST_REQ);
      // Offset within the line never carries into the bank byte.
      if (state_n == ST_REQ) mem_addr_r <= {pbr_r, pcl_r, cnt_n};
      cache_we_r <= capture_s;
      if (capture_s) begin
        cache_waddr_r <= fill_waddr_s;
        cache_wdata_r <= mem_data;
      end
      if (flush)         line_valid_r        <= '0;
      else if (finish_s) line_valid_r[idx_r] <= 1'b1;
      fill_busy_r  <= (state_n != ST_IDLE);
      fill_done_r  <= hit_s | finish_s;
      fill_abort_r <= abort_s;
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign cache_we    = cache_we_r;
  assign cache_waddr = cache_waddr_r;
  assign cache_wdata = cache_wdata_r;
  assign line_valid  = line_valid_r;
  assign fill_busy   = fill_busy_r;
  assign fill_done   = fill_done_r;
  assign fill_abort  = fill_abort_r;

`ifdef GSU_CACHE_FILL_PERF_EN
  logic [15:0] perf_fills_r, perf_stall_r;

  // Saturating counters of completed fills and busy cycles.
  always_ff @(posedge clkin) begin
    if (rst) begin
      perf_fills_r <= 16'd0;
      perf_stall_r <= 16'd0;
    end else begin
      if (finish_s)    perf_fills_r <= sat_inc16(perf_fills_r);
      if (fill_busy_r) perf_stall_r <= sat_inc16(perf_stall_r);
    end
  end

  assign perf_fills = perf_fills_r;
  assign perf_stall = perf_stall_r;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_gsu_cache_fill.sv
// Scoreboard bench for gsu_cache_fill: the stimulus side predicts reads,
// cache writes and done/abort events into queues; a negedge monitor pops
// and compares whenever the DUT presents one of them.
module tb_gsu_cache_fill;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  logic [15:0] miss_pc = 16'd0;
  logic [7:0]  miss_pbr = 8'd0;
  logic [15:0] cbr = 16'd0;
  logic        flush = 1'b0;
  logic        ron = 1'b1;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'd0;
  logic        cache_we;
  logic [8:0]  cache_waddr;
  logic [7:0]  cache_wdata;
  logic [31:0] line_valid;
  logic        fill_busy, fill_done, fill_abort;
`ifdef GSU_CACHE_FILL_PERF_EN
  logic [15:0] perf_fills, perf_stall;
`endif

  gsu_cache_fill dut (
    .clkin(clkin), .rst(rst), .miss_req(miss_req), .miss_pc(miss_pc),
    .miss_pbr(miss_pbr), .cbr(cbr), .flush(flush), .ron(ron),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .line_valid(line_valid), .fill_busy(fill_busy), .fill_done(fill_done),
    .fill_abort(fill_abort)
`ifdef GSU_CACHE_FILL_PERF_EN
    , .perf_fills(perf_fills), .perf_stall(perf_stall)
`endif
  );

  always #5 clkin = ~clkin;

  typedef struct { bit abort; logic [31:0] lv; } evt_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] exp_rd[$];
  logic [16:0] exp_wr[$];
  evt_t        exp_evt[$];
  logic [31:0] lv_model = 32'd0;
  int          wr_count = 0;
  int          req_cycles = 0;
  bit          ack_en = 1'b1;
  int          ack_pct = 100;
  bit          ron_rand = 1'b0;
  logic        ron_cmd = 1'b1;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game Pak bus model: ron ownership and randomly timed acknowledges.
  always @(posedge clkin) begin
    #2;
    if (ron_rand) begin
      if ($urandom_range(0, 9) == 0) ron = ~ron;
    end else begin
      ron = ron_cmd;
    end
    if (mem_req && ron && ack_en && ($urandom_range(0, 99) < ack_pct)) begin
      mem_ack  = 1'b1;
      mem_data = mem_byte(mem_addr);
    end else begin
      mem_ack  = 1'b0;
      mem_data = 8'($urandom);
    end
  end

  // Monitor: pops expectations whenever the DUT shows a read, write or event.
  always @(negedge clkin) begin
    evt_t e;
    if (mem_req) req_cycles++;
    if (mem_req && mem_ack) begin
      if (exp_rd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_extra: read of %06h, expected none", mem_addr);
      end else chk("mem_addr", {8'd0, mem_addr}, {8'd0, exp_rd.pop_front()});
    end
    if (cache_we) begin
      wr_count++;
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_extra: write %03h=%02h, expected none", cache_waddr, cache_wdata);
      end else chk("cache_wr", {15'd0, cache_waddr, cache_wdata}, {15'd0, exp_wr.pop_front()});
    end
    if (fill_done || fill_abort) begin
      if (exp_evt.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL evt_extra: done=%0b abort=%0b, expected none", fill_done, fill_abort);
      end else begin
        e = exp_evt.pop_front();
        chk("evt_abort", {31'd0, fill_abort}, {31'd0, e.abort});
        chk("evt_done", {31'd0, fill_done}, {31'd0, !e.abort});
        chk("evt_line_valid", line_valid, e.lv);
      end
    end
  end

  // Reference: predict the whole line from the address rules.
  task automatic prepare(input logic [15:0] p_pc, input logic [7:0] p_pbr,
                         input logic [15:0] p_cbr, input int abort_at, output bit hit);
    logic [15:0] base, w;
    int          idx, nb;
    evt_t        e;
    base = {p_pc[15:4], 4'h0};
    w    = (base + p_cbr) & 16'h01FF;
    idx  = int'(w[8:4]);
    hit  = lv_model[idx];
    if (!hit) begin
      nb = (abort_at >= 0) ? abort_at : 16;
      for (int i = 0; i < 16; i++)
        if (abort_at < 0 || i <= abort_at) exp_rd.push_back({p_pbr, base + 16'(i)});
      for (int i = 0; i < nb; i++) begin
        w = (base + 16'(i) + p_cbr) & 16'h01FF;
        exp_wr.push_back({w[8:0], mem_byte({p_pbr, base + 16'(i)})});
      end
      if (abort_at < 0) lv_model[idx] = 1'b1;
      else              lv_model = 32'd0;
    end
    e.abort = (!hit && abort_at >= 0);
    e.lv    = lv_model;
    exp_evt.push_back(e);
  endtask

  task automatic do_fill(input logic [15:0] p_pc, input logic [7:0] p_pbr,
                         input logic [15:0] p_cbr, input int abort_at);
    bit hit;
    int cyc, base_wr, base_req;
    prepare(p_pc, p_pbr, p_cbr, abort_at, hit);
    base_wr  = wr_count;
    base_req = req_cycles;
    miss_pc = p_pc; miss_pbr = p_pbr; cbr = p_cbr; miss_req = 1'b1;
    @(posedge clkin); #1;
    // Request fields change after acceptance; the DUT must ignore them.
    miss_pc = 16'($urandom); miss_pbr = 8'($urandom); cbr = 16'($urandom) & 16'hFFF0;
    if (hit) begin
      chk("hit_done_next", {31'd0, fill_done}, 32'd1);
      chk("hit_busy", {31'd0, fill_busy}, 32'd0);
      @(posedge clkin); #1;
      miss_req = 1'b0;
      chk("hit_no_mem_req", req_cycles, base_req);
    end else begin
      chk("busy_after_accept", {31'd0, fill_busy}, 32'd1);
      cyc = 1;
      while (!(fill_done || fill_abort) && cyc < 3000) begin
        @(posedge clkin); #1;
        cyc++;
      end
      if (cyc >= 3000) begin
        n_checks++; n_fail++;
        $display("FAIL fill_timeout: no done/abort after %0d cycles", cyc);
      end else if (fill_done) begin
        chk("latency_ge33", {31'd0, cyc >= 33}, 32'd1);
        chk("writes_per_line", wr_count - base_wr, 32'd16);
      end
      @(posedge clkin); #1;
      miss_req = 1'b0;
    end
    @(posedge clkin); #1;
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_count < target && n < 1000) begin
      @(posedge clkin); #1;
      n++;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, {8'd0, mem_addr}, 32'd0);
    chk({tag, "_cache_we"}, {31'd0, cache_we}, 32'd0);
    chk({tag, "_cache_wr"}, {15'd0, cache_waddr, cache_wdata}, 32'd0);
    chk({tag, "_line_valid"}, line_valid, 32'd0);
    chk({tag, "_status"}, {29'd0, fill_busy, fill_done, fill_abort}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r0, w0;
    repeat (3) @(posedge clkin);
    #1 rst = 1'b0;
    chk_outputs_zero("reset");

    // Basic fill and CBR wrap
    do_fill(16'h8023, 8'h01, 16'h0000, -1);
    do_fill(16'h0010, 8'h00, 16'h01F0, -1);

    // Bus loss while byte 5 is pending
    b = wr_count;
    fork
      do_fill(16'h1234, 8'h7E, 16'h0100, -1);
      begin
        wait_wr(b + 5);
        ack_en = 1'b0; ron_cmd = 1'b0;
        @(posedge clkin); #1;
        for (int k = 0; k < 10; k++) begin
          chk("loss_mem_req_low", {31'd0, mem_req}, 32'd0);
          chk("loss_busy", {31'd0, fill_busy}, 32'd1);
          @(posedge clkin); #1;
        end
        ron_cmd = 1'b1; ack_en = 1'b1;
      end
    join

    // Flush while byte 7 is being fetched
    b = wr_count;
    r0 = 0; w0 = 0;
    fork
      do_fill(16'h4567, 8'h02, 16'h0030, 7);
      begin
        wait_wr(b + 7);
        flush = 1'b1; miss_req = 1'b0;
        @(posedge clkin); #1;
        flush = 1'b0;
        exp_rd.delete();
        r0 = req_cycles; w0 = wr_count;
      end
    join
    repeat (20) @(posedge clkin);
    #1;
    chk("abort_no_req", req_cycles, r0);
    chk("abort_no_write", wr_count, w0);
    chk("abort_line_valid", line_valid, 32'd0);

    // Refill, then the same miss must hit
    do_fill(16'h8023, 8'h01, 16'h0000, -1);
    do_fill(16'h8023, 8'h01, 16'h0000, -1);

    // Random fills with random bus ownership and ack timing
    ron_rand = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ack_pct = int'($urandom_range(30, 100));
      do_fill(16'($urandom), 8'($urandom), 16'($urandom) & 16'hFFF0, -1);
    end
    ron_rand = 1'b0; ack_pct = 100;
    repeat (2) @(posedge clkin);
    #1;

    // Flush while idle
    flush = 1'b1;
    @(posedge clkin); #1;
    flush = 1'b0;
    lv_model = 32'd0;
    chk("idle_flush_lv", line_valid, 32'd0);
    chk("idle_flush_no_abort", {31'd0, fill_abort}, 32'd0);

    // Reset during REQ
    begin
      bit hit;
      int n = 0;
      prepare(16'hABC0, 8'h33, 16'h0000, -1, hit);
      miss_pc = 16'hABC0; miss_pbr = 8'h33; cbr = 16'h0000; miss_req = 1'b1;
      while (!mem_req && n < 100) begin
        @(posedge clkin); #1;
        n++;
      end
      chk("reach_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      @(posedge clkin); #1;
      rst = 1'b0; miss_req = 1'b0;
      chk_outputs_zero("midfill_reset");
      exp_rd.delete(); exp_wr.delete(); exp_evt.delete();
      lv_model = 32'd0;
      repeat (5) @(posedge clkin);
      #1;
    end
    do_fill(16'hABC0, 8'h33, 16'h0000, -1);

    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("evt_queue_empty", exp_evt.size(), 32'd0);
    chk("final_line_valid", line_valid, lv_model);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
